// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with optional same-cycle
// write-to-read bypass and a per-register pending scoreboard used by decode
// to spot RAW hazards against producers still in flight.
module reg_file_mp #(
  parameter int NUM_REG        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32,
  parameter int NUM_RD         = 2,
  parameter int NUM_WR         = 2,
  parameter bit BYPASS         = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*REG_WIDTH-1:0]      wr_data,
  input  logic                             alloc_en,
  input  logic [REG_ADDR_WIDTH-1:0]        alloc_addr,
  output logic [NUM_REG-1:0]               pending
);

  logic [REG_WIDTH-1:0]      r_regs [NUM_REG];
  logic [NUM_REG-1:0]        r_pending;
  logic [NUM_REG-1:0]        w_pend_next;
  logic [REG_ADDR_WIDTH-1:0] w_rd_addr [NUM_RD];
  logic [REG_WIDTH-1:0]      w_rd_data [NUM_RD];
  logic [NUM_RD-1:0]         w_rd_busy;
  logic [REG_ADDR_WIDTH-1:0] w_wr_addr [NUM_WR];
  logic [REG_WIDTH-1:0]      w_wr_data [NUM_WR];

  // An address is backed by storage only below NUM_REG; the rest are holes.
  function automatic logic inRange(input logic [REG_ADDR_WIDTH-1:0] a);
    return 32'(a) < 32'(NUM_REG);
  endfunction

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign w_rd_addr[k]                        = rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign rd_data[k*REG_WIDTH +: REG_WIDTH]   = w_rd_data[k];
    assign rd_busy[k]                          = w_rd_busy[k];
  end

  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign w_wr_addr[w] = wr_addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign w_wr_data[w] = wr_data[w*REG_WIDTH +: REG_WIDTH];
  end

  assign pending = r_pending;

  // Store write-port data; ports are visited in ascending order so the
  // highest-index port targeting the same register lands last and wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (w_wr_addr[w] != '0) && inRange(w_wr_addr[w])) begin
          r_regs[w_wr_addr[w]] <= w_wr_data[w];
        end
      end
    end
  end

  // Scoreboard next state: writeback clears, alloc sets, and alloc is applied
  // last so a new producer issued alongside a writeback keeps the bit high.
  always_comb begin
    w_pend_next    = r_pending;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (w_wr_addr[w] != '0) && inRange(w_wr_addr[w])) begin
        w_pend_next[w_wr_addr[w]] = 1'b0;
      end
    end
    if (alloc_en && (alloc_addr != '0) && inRange(alloc_addr)) begin
      w_pend_next[alloc_addr] = 1'b1;
    end
    w_pend_next[0] = 1'b0;
  end

  // Scoreboard register; reset discards every in-flight allocation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_next;
    end
  end

  // Combinational read: x0 and unbacked addresses read as idle zero; with
  // bypass the highest matching write port overrides storage and hides busy,
  // since the producer is completing in this very cycle.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_data[k] = '0;
      w_rd_busy[k] = 1'b0;
      if ((w_rd_addr[k] != '0) && inRange(w_rd_addr[k])) begin
        w_rd_data[k] = r_regs[w_rd_addr[k]];
        w_rd_busy[k] = r_pending[w_rd_addr[k]];
        if (BYPASS) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (w_wr_addr[w] == w_rd_addr[k])) begin
              w_rd_data[k] = w_wr_data[w];
              w_rd_busy[k] = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: drives a bypassing and a non-bypassing reg_file_mp with the
// same stimulus and checks both against a behavioural model via a scoreboard.
module tb_reg_file_mp;

  localparam int NR = 28;

  typedef struct {
    int                cyc;
    logic [63:0]       dataB;
    logic [63:0]       dataN;
    logic [1:0]        busyB;
    logic [1:0]        busyN;
    logic [NR-1:0]     pend;
  } expT;

  logic        clk = 1'b0;
  logic        rstN;
  logic [9:0]  rdAddr;
  logic [1:0]  wrEn;
  logic [9:0]  wrAddr;
  logic [63:0] wrData;
  logic        allocEn;
  logic [4:0]  allocAddr;

  logic [63:0]   rdDataB, rdDataN;
  logic [1:0]    rdBusyB, rdBusyN;
  logic [NR-1:0] pendB, pendN;

  logic [31:0]   modelMem [NR];
  logic [NR-1:0] modelPend;
  expT           expQ [$];
  int            total = 0;
  int            bad = 0;
  int            cycleNo = 0;

  reg_file_mp #(.NUM_REG(NR), .BYPASS(1'b1)) dutB (
    .clk(clk), .rst_n(rstN), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_busy(rdBusyB),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .alloc_en(allocEn),
    .alloc_addr(allocAddr), .pending(pendB)
  );

  reg_file_mp #(.NUM_REG(NR), .BYPASS(1'b0)) dutN (
    .clk(clk), .rst_n(rstN), .rd_addr(rdAddr), .rd_data(rdDataN), .rd_busy(rdBusyN),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .alloc_en(allocEn),
    .alloc_addr(allocAddr), .pending(pendN)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Model view of a read: architectural value, overridden by the last
  // enabled write to that address when forwarding is on.
  function automatic void modelRead(input int a, input bit byp, input logic [1:0] wen,
                                    input int wa0, input logic [31:0] wd0,
                                    input int wa1, input logic [31:0] wd1,
                                    output logic [31:0] d, output logic b);
    d = 32'h0;
    b = 1'b0;
    if (a != 0 && a < NR) begin
      d = modelMem[a];
      b = modelPend[a];
      if (byp && wen[0] && wa0 == a) begin d = wd0; b = 1'b0; end
      if (byp && wen[1] && wa1 == a) begin d = wd1; b = 1'b0; end
    end
  endfunction

  task automatic compareVal(input string name, input int cyc, input logic [63:0] act,
                            input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, queue the expected outputs, then advance the model.
  task automatic applyStimulus(input logic rst, input logic [1:0] wen,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic al, input logic [4:0] aa,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    expT e;
    logic [31:0] d;
    logic b;
    @(posedge clk);
    #1;
    rstN = ~rst; wrEn = wen; wrAddr = {wa1, wa0}; wrData = {wd1, wd0};
    allocEn = al; allocAddr = aa; rdAddr = {ra1, ra0};
    cycleNo++;
    e.cyc = cycleNo;
    modelRead(int'(ra0), 1'b1, wen, int'(wa0), wd0, int'(wa1), wd1, d, b);
    e.dataB[31:0] = d; e.busyB[0] = b;
    modelRead(int'(ra1), 1'b1, wen, int'(wa0), wd0, int'(wa1), wd1, d, b);
    e.dataB[63:32] = d; e.busyB[1] = b;
    modelRead(int'(ra0), 1'b0, wen, int'(wa0), wd0, int'(wa1), wd1, d, b);
    e.dataN[31:0] = d; e.busyN[0] = b;
    modelRead(int'(ra1), 1'b0, wen, int'(wa0), wd0, int'(wa1), wd1, d, b);
    e.dataN[63:32] = d; e.busyN[1] = b;
    e.pend = modelPend;
    expQ.push_back(e);
    if (rst) begin
      for (int i = 0; i < NR; i++) modelMem[i] = 32'h0;
      modelPend = '0;
    end else begin
      for (int i = 1; i < NR; i++) begin
        if (wen[0] && int'(wa0) == i) begin modelMem[i] = wd0; modelPend[i] = 1'b0; end
        if (wen[1] && int'(wa1) == i) begin modelMem[i] = wd1; modelPend[i] = 1'b0; end
        if (al && int'(aa) == i) modelPend[i] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input expT e);
    compareVal("rdDataB", e.cyc, rdDataB, e.dataB);
    compareVal("rdDataN", e.cyc, rdDataN, e.dataN);
    compareVal("rdBusyB", e.cyc, 64'(rdBusyB), 64'(e.busyB));
    compareVal("rdBusyN", e.cyc, 64'(rdBusyN), 64'(e.busyN));
    compareVal("pendB", e.cyc, 64'(pendB), 64'(e.pend));
    compareVal("pendN", e.cyc, 64'(pendN), 64'(e.pend));
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response;
  // sample mid-cycle and compare against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Directed plan followed by randomized traffic with occasional resets.
  initial begin
    rstN = 1'b0; wrEn = '0; wrAddr = '0; wrData = '0;
    allocEn = 1'b0; allocAddr = '0; rdAddr = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < NR; i++) modelMem[i] = 32'h0;
    modelPend = '0;

    for (int i = 0; i < 32; i += 2)
      applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(i + 1));

    applyStimulus(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);

    applyStimulus(1'b0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd0);
    applyStimulus(1'b0, 2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7);

    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    applyStimulus(1'b0, 2'b10, 5'd0, 32'h0, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd9);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);

    applyStimulus(1'b0, 2'b01, 5'd3, 32'h77, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3, 5'd0);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd30, 5'd3, 5'd30);

    applyStimulus(1'b0, 2'b01, 5'd12, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd0);
    applyStimulus(1'b1, 2'b01, 5'd12, 32'hBB, 5'd0, 32'h0, 1'b1, 5'd4, 5'd12, 5'd3);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd3);
    applyStimulus(1'b0, 2'b01, 5'd12, 32'h1, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);

    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa0, wa1, ra0, ra1, aa;
      wa0 = 5'($urandom_range(0, 31));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
      aa  = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)),
                    wa0, $urandom, wa1, $urandom, 1'($urandom_range(0, 1)), aa, ra0, ra1);
    end

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got=%0d want=0 entries left", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
